// File: rtl/pc_gen.sv
// Program-counter generator: holds the architectural PC, runs the post-reset
// boot delay, and picks the next PC from trap, jump, halt, stall or increment.
module pc_gen #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                BOOT_DELAY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              jump_en_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              trap_en_i,
   input  logic [ADDR_W-1:0] trap_addr_i,
   input  logic              halt_req_i,
   input  logic              resume_req_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              pc_valid_o,
   output logic              halted_o,
   output logic              misalign_o,
   output logic [ADDR_W-1:0] misalign_addr_o
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   localparam int     CNT_W       = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
   localparam int     BOOT_LAST   = (BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0;
   localparam state_t RESET_STATE = (BOOT_DELAY == 0) ? RUN : BOOT;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ADDR_W-1:0] pc_nxt, maddr_nxt, trap_vec;
   logic              mis_nxt;

   // Low vector bits are masked rather than sliced so every input bit is consumed.
   assign trap_vec = trap_addr_i & ~ADDR_W'(3);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pc_nxt    = pc_o;
      mis_nxt   = 1'b0;
      maddr_nxt = misalign_addr_o;
      case (state)
         BOOT: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(BOOT_LAST)) state_nxt = RUN;
         end
         RUN: begin
            if (trap_en_i) begin
               pc_nxt = trap_vec;
            end else if (jump_en_i) begin
               if (jump_addr_i[1:0] == 2'b00) begin
                  pc_nxt = jump_addr_i;
               end else begin
                  mis_nxt   = 1'b1;
                  maddr_nxt = jump_addr_i;
               end
            end else if (halt_req_i) begin
               state_nxt = HALT;
            end else if (!stall_i) begin
               pc_nxt = pc_o + ADDR_W'(4);
            end
         end
         HALT: begin
            if (trap_en_i) begin
               pc_nxt    = trap_vec;
               state_nxt = RUN;
            end else if (resume_req_i) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = RESET_STATE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with pc_o.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= RESET_STATE;
         cnt             <= '0;
         pc_o            <= RESET_PC;
         pc_valid_o      <= (BOOT_DELAY == 0);
         halted_o        <= 1'b0;
         misalign_o      <= 1'b0;
         misalign_addr_o <= '0;
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         pc_o            <= pc_nxt;
         pc_valid_o      <= (state_nxt == RUN);
         halted_o        <= (state_nxt == HALT);
         misalign_o      <= mis_nxt;
         misalign_addr_o <= maddr_nxt;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected outputs are queued as each cycle's
// stimulus is driven, then popped and compared one clock later.
module tb_pc_gen;

   localparam int          ADDR_W = 32;
   localparam logic [31:0] RPC    = 32'h0000_0100;

   typedef struct packed {
      logic [31:0] pc;
      logic        valid;
      logic        halted;
      logic        mis;
      logic [31:0] maddr;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall_i, jump_en_i, trap_en_i, halt_req_i, resume_req_i;
   logic [ADDR_W-1:0] jump_addr_i, trap_addr_i;
   logic [ADDR_W-1:0] pc_o, misalign_addr_o;
   logic              pc_valid_o, halted_o, misalign_o;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   pc_gen #(.ADDR_W(ADDR_W), .RESET_PC(RPC), .BOOT_DELAY(4)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i),
      .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
      .trap_en_i(trap_en_i), .trap_addr_i(trap_addr_i),
      .halt_req_i(halt_req_i), .resume_req_i(resume_req_i),
      .pc_o(pc_o), .pc_valid_o(pc_valid_o), .halted_o(halted_o),
      .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o)
   );

   task automatic idle();
      stall_i = 0; jump_en_i = 0; trap_en_i = 0; halt_req_i = 0; resume_req_i = 0;
      jump_addr_i = '0; trap_addr_i = '0;
   endtask

   // Queue the expected post-edge outputs, clock once, then pop and compare.
   task automatic step(input string tag, input logic [31:0] pc, input logic v,
                       input logic h, input logic m, input logic [31:0] ma);
      exp_t e;
      q.push_back('{pc, v, h, m, ma});
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      assert (pc_o === e.pc) else begin
         fails++; $error("FAIL %s pc: got %h want %h", tag, pc_o, e.pc);
      end
      tests++;
      assert (pc_valid_o === e.valid) else begin
         fails++; $error("FAIL %s valid: got %b want %b", tag, pc_valid_o, e.valid);
      end
      tests++;
      assert (halted_o === e.halted) else begin
         fails++; $error("FAIL %s halted: got %b want %b", tag, halted_o, e.halted);
      end
      tests++;
      assert (misalign_o === e.mis) else begin
         fails++; $error("FAIL %s misalign: got %b want %b", tag, misalign_o, e.mis);
      end
      tests++;
      assert (misalign_addr_o === e.maddr) else begin
         fails++; $error("FAIL %s maddr: got %h want %h", tag, misalign_addr_o, e.maddr);
      end
      idle();
   endtask

   initial begin
      idle();
      rst = 1;
      step("reset0", RPC, 0, 0, 0, 0);
      step("reset1", RPC, 0, 0, 0, 0);
      rst = 0;
      // Boot: redirects and halt must be ignored.
      jump_en_i = 1; jump_addr_i = 32'h700; trap_en_i = 1; trap_addr_i = 32'h600;
      step("boot1", RPC, 0, 0, 0, 0);
      halt_req_i = 1; stall_i = 1;
      step("boot2", RPC, 0, 0, 0, 0);
      step("boot3", RPC, 0, 0, 0, 0);
      step("first", RPC, 1, 0, 0, 0);
      step("seq1", 32'h104, 1, 0, 0, 0);
      step("seq2", 32'h108, 1, 0, 0, 0);

      // Redirect priority.
      jump_en_i = 1; jump_addr_i = 32'h200;
      step("jmp200", 32'h200, 1, 0, 0, 0);
      trap_en_i = 1; trap_addr_i = 32'h803; jump_en_i = 1; jump_addr_i = 32'h400; stall_i = 1;
      step("trap_prio", 32'h800, 1, 0, 0, 0);
      jump_en_i = 1; jump_addr_i = 32'h400; stall_i = 1;
      step("jmp_stall", 32'h400, 1, 0, 0, 0);

      // Misaligned jumps, including back-to-back.
      jump_en_i = 1; jump_addr_i = 32'h300;
      step("jmp300", 32'h300, 1, 0, 0, 0);
      jump_en_i = 1; jump_addr_i = 32'h302;
      step("mis1", 32'h300, 1, 0, 1, 32'h302);
      step("after_mis", 32'h304, 1, 0, 0, 32'h302);
      jump_en_i = 1; jump_addr_i = 32'h305;
      step("mis2", 32'h304, 1, 0, 1, 32'h305);
      jump_en_i = 1; jump_addr_i = 32'h30A;
      step("mis3", 32'h304, 1, 0, 1, 32'h30A);
      step("after_mis3", 32'h308, 1, 0, 0, 32'h30A);
      trap_en_i = 1; trap_addr_i = 32'h42; jump_en_i = 1; jump_addr_i = 32'h302;
      step("trap_mis", 32'h40, 1, 0, 0, 32'h30A);
      stall_i = 1;
      step("stall", 32'h40, 1, 0, 0, 32'h30A);

      // Halt with a redirect stays in RUN; then halt/resume.
      halt_req_i = 1; jump_en_i = 1; jump_addr_i = 32'h500;
      step("halt_jmp", 32'h500, 1, 0, 0, 32'h30A);
      halt_req_i = 1;
      step("halt", 32'h500, 0, 1, 0, 32'h30A);
      jump_en_i = 1; jump_addr_i = 32'h900; stall_i = 1;
      step("halt_jmp_ign", 32'h500, 0, 1, 0, 32'h30A);
      resume_req_i = 1; halt_req_i = 1;
      step("resume", 32'h500, 1, 0, 0, 32'h30A);
      step("post_resume", 32'h504, 1, 0, 0, 32'h30A);
      halt_req_i = 1;
      step("halt2", 32'h504, 0, 1, 0, 32'h30A);
      trap_en_i = 1; trap_addr_i = 32'h41;
      step("halt_trap", 32'h40, 1, 0, 0, 32'h30A);
      step("post_trap", 32'h44, 1, 0, 0, 32'h30A);

      // Wrap-around.
      jump_en_i = 1; jump_addr_i = 32'hFFFF_FFFC;
      step("wrap0", 32'hFFFF_FFFC, 1, 0, 0, 32'h30A);
      step("wrap1", 32'h0, 1, 0, 0, 32'h30A);
      step("wrap2", 32'h4, 1, 0, 0, 32'h30A);

      // Reset while halted.
      halt_req_i = 1;
      step("halt3", 32'h4, 0, 1, 0, 32'h30A);
      rst = 1;
      step("rst_halt", RPC, 0, 0, 0, 0);
      rst = 0;
      step("reboot1", RPC, 0, 0, 0, 0);
      step("reboot2", RPC, 0, 0, 0, 0);
      step("reboot3", RPC, 0, 0, 0, 0);
      step("reboot_first", RPC, 1, 0, 0, 0);

      // Reset in RUN with a jump pending.
      rst = 1; jump_en_i = 1; jump_addr_i = 32'h600;
      step("rst_run", RPC, 0, 0, 0, 0);
      rst = 0;
      step("reboot_b1", RPC, 0, 0, 0, 0);
      step("reboot_b2", RPC, 0, 0, 0, 0);
      step("reboot_b3", RPC, 0, 0, 0, 0);
      step("reboot_b_first", RPC, 1, 0, 0, 0);
      step("reboot_b_seq", 32'h104, 1, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
